pipe_out_buffer: RTL

//  FPGA-to-host return path for lab blocks. Fabric logic pushes result words through a valid/ready port.
//  The host drains them through an okPipeOut-style read strobe: data must appear the cycle after ep_read.
//  A status word reports occupancy and error flags, and is mapped to a WireOut.
//  The block sits between the design under test and the okHost endpoints, all on okClk.

---
 rtl/okpipe_pkg.sv | 35 +++
 rtl/sync_fifo_ram.sv | 33 +++
 rtl/pipe_out_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/okpipe_pkg.sv
// Shared definitions for the okHost pipe-out return path: status word layout,
// read classification and the saturating drop-counter helper.
package okpipe_pkg;

    localparam int STATUS_OVF = 31;
    localparam int STATUS_UDF = 30;
    localparam int DROP_LSB   = 16;
    localparam int DROP_W     = 8;
    localparam int COUNT_W    = 16;
    localparam int PIPE_W     = 32;
    localparam int RSVD_W     = PIPE_W - 2 - DROP_W - COUNT_W;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    // Bit order mirrors the WireOut map: overflow at 31, underflow at 30.
    typedef struct packed {
        logic              overflow;
        logic              underflow;
        logic [RSVD_W-1:0] reserved;
        logic [DROP_W-1:0] dropCnt;
        logic [COUNT_W-1:0] count;
    } statusWord_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_WORD,
        RD_EMPTY
    } readAction_t;

    function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_ONE;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the pipe-out buffer: one write port, one registered read
// port, written so that synthesis maps it onto a simple dual-port block RAM.
module sync_fifo_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset; a reset term would
    // stop the tools from packing them into a block RAM. The owner of the read
    // data masks it until a valid read has happened.
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/pipe_out_buffer.sv
// FPGA-to-host return buffer: valid/ready producer port in, okPipeOut-style read
// strobe out with one-cycle latency, plus a packed status word for a WireOut.
module pipe_out_buffer
    import okpipe_pkg::*;
#(
    parameter  int DATA_W = PIPE_W,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              okClk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ep_read,
    output logic [DATA_W-1:0] ep_datain,
    output logic [31:0]       status
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   countNext;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              outValid;
    logic [DROP_W-1:0] dropCnt;
    logic [DATA_W-1:0] ramQ;

    logic              wrAccept;
    logic              wrDrop;
    readAction_t       rdAction;
    statusWord_t       statusWord;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        wrAccept  = 1'b0;
        wrDrop    = 1'b0;
        rdAction  = RD_NONE;
        countNext = count;

        // Acceptance looks only at the registered full flag, never at ep_read.
        if (!clr) begin
            wrAccept = in_valid && !full;
            wrDrop   = in_valid && full;
            if (ep_read) begin
                rdAction = (count != '0) ? RD_WORD : RD_EMPTY;
            end
        end

        case ({wrAccept, rdAction == RD_WORD})
            2'b10:   countNext = count + CNT_ONE;
            2'b01:   countNext = count - CNT_ONE;
            default: countNext = count;
        endcase
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (okClk),
        .wrEn   (wrAccept),
        .wrAddr (wrPtr),
        .wrData (in_data),
        .rdEn   (rdAction == RD_WORD),
        .rdAddr (rdPtr),
        .rdData (ramQ)
    );

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dropCnt   <= '0;
            outValid  <= 1'b0;
        end else if (clr) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dropCnt   <= '0;
            outValid  <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (wrDrop) begin
                overflow <= 1'b1;
                dropCnt  <= satInc(dropCnt);
            end
            case (rdAction)
                RD_WORD: begin
                    rdPtr    <= rdPtr + PTR_ONE;
                    outValid <= 1'b1;
                end
                RD_EMPTY: begin
                    underflow <= 1'b1;
                    outValid  <= 1'b0;
                end
                default: ;
            endcase
            count <= countNext;
            full  <= (countNext == CNT_FULL);
        end
    end

    // The RAM register holds between reads; outValid forces zero after
    // reset, clr or an underflow read.
    assign ep_datain = outValid ? ramQ : '0;
    assign in_ready  = !full;

    always_comb begin
        statusWord           = '0;
        statusWord.overflow  = overflow;
        statusWord.underflow = underflow;
        statusWord.dropCnt   = dropCnt;
        statusWord.count     = COUNT_W'(count);
    end

    assign status = statusWord;

endmodule
